// File: rtl/param_alu_cpu.sv
// Programmable ALU sequencer: fetches {opcode, A, B} words from a loadable memory
// and presents each result under a result_ready/next_out handshake. Optional MUL: PARAM_ALU_CPU_MUL_EN.
module param_alu_cpu #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       prog_we,
  input  logic [$clog2(DEPTH)-1:0]   prog_addr,
  input  logic [4+2*WIDTH-1:0]       prog_data,
  input  logic                       start,
  input  logic                       next_out,
  output logic [3:0]                 opcode,
  output logic [WIDTH-1:0]           operand_A_out,
  output logic [WIDTH-1:0]           operand_B_out,
  output logic [WIDTH-1:0]           result_out_cpu,
  output logic                       carry_out_cpu,
  output logic                       borrow_out_cpu,
  output logic                       result_ready,
  output logic [$clog2(DEPTH)-1:0]   pc_out,
  output logic                       halted
);
  localparam int PC_W = $clog2(DEPTH);
  localparam int IW   = 4 + 2 * WIDTH;

  typedef enum logic [2:0] {IDLE, FETCH, EXEC, HOLD, HALTED} state_t;

  state_t             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [3:0]         opcode_q, opcode_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, result_q, result_d;
  logic               carry_q, carry_d, borrow_q, borrow_d;
  logic               ready_q, ready_d, halted_q, halted_d;

  logic [IW-1:0]      mem [DEPTH];
  logic [IW-1:0]      ir_q;
  logic               mem_we;

  // Loading is only allowed while the sequencer is parked.
  assign mem_we = prog_we && (state_q == IDLE || state_q == HALTED);

  always_ff @(posedge clk) begin
    if (mem_we) mem[prog_addr] <= prog_data;
    if (state_q == FETCH) ir_q <= mem[pc_q];
  end

  logic [3:0]       ir_op;
  logic [WIDTH-1:0] ir_a, ir_b;
  assign ir_op = ir_q[IW-1 -: 4];
  assign ir_a  = ir_q[2*WIDTH-1 -: WIDTH];
  assign ir_b  = ir_q[WIDTH-1:0];

  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_bw;
  logic [WIDTH:0]   sum_w;
`ifdef PARAM_ALU_CPU_MUL_EN
  logic [2*WIDTH-1:0] prod;
`endif

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_bw  = 1'b0;
    sum_w   = '0;
`ifdef PARAM_ALU_CPU_MUL_EN
    prod    = '0;
`endif
    case (ir_op)
      4'h0: begin
        sum_w   = {1'b0, ir_a} + {1'b0, ir_b};
        alu_res = sum_w[WIDTH-1:0];
        alu_c   = sum_w[WIDTH];
      end
      4'h1: begin
        alu_res = ir_a - ir_b;
        alu_bw  = (ir_a < ir_b);
      end
      4'h2: alu_res = ir_a & ir_b;
      4'h3: alu_res = ir_a | ir_b;
      4'h4: alu_res = ir_a ^ ir_b;
      4'h5: alu_res = ~ir_a;
      4'h6: begin
        alu_res = {ir_a[WIDTH-2:0], 1'b0};
        alu_c   = ir_a[WIDTH-1];
      end
      4'h7: begin
        alu_res = {1'b0, ir_a[WIDTH-1:1]};
        alu_c   = ir_a[0];
      end
      4'h8: begin
        sum_w   = {1'b0, ir_a} + (WIDTH+1)'(1);
        alu_res = sum_w[WIDTH-1:0];
        alu_c   = sum_w[WIDTH];
      end
      4'h9: begin
        alu_res = ir_a - WIDTH'(1);
        alu_bw  = (ir_a == '0);
      end
`ifdef PARAM_ALU_CPU_MUL_EN
      4'hA: begin
        prod    = {{WIDTH{1'b0}}, ir_a} * {{WIDTH{1'b0}}, ir_b};
        alu_res = prod[WIDTH-1:0];
        alu_c   = |prod[2*WIDTH-1:WIDTH];
      end
`endif
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    opcode_d = opcode_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    carry_d  = carry_q;
    borrow_d = borrow_q;
    ready_d  = ready_q;
    halted_d = halted_q;
    case (state_q)
      IDLE, HALTED: begin
        if (start) begin
          state_d  = FETCH;
          pc_d     = '0;
          halted_d = 1'b0;
        end
      end
      FETCH: state_d = EXEC;
      EXEC: begin
        // HALT leaves the previous result registers and pc untouched.
        if (ir_op == 4'hF) begin
          state_d  = HALTED;
          halted_d = 1'b1;
        end else begin
          state_d  = HOLD;
          opcode_d = ir_op;
          a_d      = ir_a;
          b_d      = ir_b;
          result_d = alu_res;
          carry_d  = alu_c;
          borrow_d = alu_bw;
          ready_d  = 1'b1;
        end
      end
      HOLD: begin
        if (next_out) begin
          ready_d = 1'b0;
          pc_d    = pc_q + PC_W'(1);
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      pc_q     <= '0;
      opcode_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
      ready_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      opcode_q <= opcode_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      borrow_q <= borrow_d;
      ready_q  <= ready_d;
      halted_q <= halted_d;
    end
  end

  assign opcode         = opcode_q;
  assign operand_A_out  = a_q;
  assign operand_B_out  = b_q;
  assign result_out_cpu = result_q;
  assign carry_out_cpu  = carry_q;
  assign borrow_out_cpu = borrow_q;
  assign result_ready   = ready_q;
  assign pc_out         = pc_q;
  assign halted         = halted_q;

endmodule

// File: tb/tb_param_alu_cpu.sv
// Directed-vector bench for param_alu_cpu (WIDTH=8, DEPTH=4); expected values hand-computed.
module tb_param_alu_cpu;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        prog_we;
  logic [1:0]  prog_addr;
  logic [19:0] prog_data;
  logic        start;
  logic        next_out;
  logic [3:0]  opcode;
  logic [7:0]  operand_A_out, operand_B_out, result_out_cpu;
  logic        carry_out_cpu, borrow_out_cpu, result_ready, halted;
  logic [1:0]  pc_out;

  int n_checks = 0;
  int n_fail   = 0;

  param_alu_cpu #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .start(start), .next_out(next_out),
    .opcode(opcode), .operand_A_out(operand_A_out), .operand_B_out(operand_B_out),
    .result_out_cpu(result_out_cpu), .carry_out_cpu(carry_out_cpu),
    .borrow_out_cpu(borrow_out_cpu), .result_ready(result_ready),
    .pc_out(pc_out), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [19:0] ins(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    return {op, a, b};
  endfunction

  function automatic logic [63:0] outs();
    return {30'd0, opcode, operand_A_out, operand_B_out, result_out_cpu,
            carry_out_cpu, borrow_out_cpu, result_ready, halted, pc_out};
  endfunction

  task automatic load(input logic [1:0] addr, input logic [19:0] data);
    prog_we   = 1'b1;
    prog_addr = addr;
    prog_data = data;
    tick();
    prog_we   = 1'b0;
  endtask

  task automatic accept();
    next_out = 1'b1;
    tick();
    next_out = 1'b0;
  endtask

  task automatic wait_ready(input string tag, output int n);
    n = 0;
    while (!result_ready && n < 20) begin
      tick();
      n++;
    end
    check_eq({tag, "_ready"}, {63'd0, result_ready}, 64'd1);
  endtask

  task automatic wait_halt(input string tag);
    int n = 0;
    while (!halted && n < 20) begin
      tick();
      n++;
    end
    check_eq({tag, "_halted"}, {63'd0, halted}, 64'd1);
  endtask

  logic [7:0] exp_mul;
  logic       exp_mulc;
  logic [1:0] wrap_pc  [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
  logic [7:0] wrap_res [6] = '{8'h00, 8'h02, 8'h40, 8'hCC, 8'h00, 8'h02};
  logic       wrap_c   [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

  initial begin
    int n;
    logic [63:0] exp_hold;
`ifdef PARAM_ALU_CPU_MUL_EN
    exp_mul  = 8'd64;
    exp_mulc = 1'b1;
`else
    exp_mul  = 8'd0;
    exp_mulc = 1'b0;
`endif
    rst = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    start = 1'b0; next_out = 1'b0;
    tick(); tick();
    check_eq("reset_outs", outs(), 64'd0);
    rst = 1'b0;
    tick();
    check_eq("idle_outs", outs(), 64'd0);

    // ADD / SUB / DEC / HALT program, cycle-exact latency and hold behaviour
    load(2'd0, ins(4'h0, 8'd200, 8'd100));
    load(2'd1, ins(4'h1, 8'd5, 8'd7));
    load(2'd2, ins(4'h9, 8'd0, 8'd0));
    load(2'd3, ins(4'hF, 8'd0, 8'd0));
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check_eq("lat_exec_not_ready", {63'd0, result_ready}, 64'd0);
    tick();
    exp_hold = {30'd0, 4'h0, 8'd200, 8'd100, 8'd44, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0};
    check_eq("add_outs", outs(), exp_hold);
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq("hold_stable", outs(), exp_hold);
    end
    accept();
    check_eq("accept_ready_low", {63'd0, result_ready}, 64'd0);
    check_eq("accept_pc", {62'd0, pc_out}, 64'd1);
    tick();
    check_eq("sub_lat_not_ready", {63'd0, result_ready}, 64'd0);
    tick();
    check_eq("sub_outs", outs(), {30'd0, 4'h1, 8'd5, 8'd7, 8'd254, 1'b0, 1'b1, 1'b1, 1'b0, 2'd1});
    accept();
    tick(); tick();
    check_eq("dec_outs", outs(), {30'd0, 4'h9, 8'd0, 8'd0, 8'd255, 1'b0, 1'b1, 1'b1, 1'b0, 2'd2});
    accept();
    wait_halt("halt3");
    check_eq("halt3_ready", {63'd0, result_ready}, 64'd0);
    check_eq("halt3_pc", {62'd0, pc_out}, 64'd3);

    // DEPTH=4 wrap with next_out tied high, plus a write attempted mid-run
    load(2'd0, ins(4'h8, 8'hFF, 8'h00));
    load(2'd1, ins(4'h6, 8'h81, 8'h00));
    load(2'd2, ins(4'h7, 8'h81, 8'h00));
    load(2'd3, ins(4'h4, 8'hF0, 8'h3C));
    start = 1'b1;
    next_out = 1'b1;
    tick();
    start = 1'b0;
    check_eq("restart_halted", {63'd0, halted}, 64'd0);
    check_eq("restart_pc", {62'd0, pc_out}, 64'd0);
    for (int i = 0; i < 6; i++) begin
      wait_ready("wrap", n);
      check_eq("wrap_latency", 64'(n), 64'd2);
      check_eq("wrap_pc", {62'd0, pc_out}, {62'd0, wrap_pc[i]});
      check_eq("wrap_res", {56'd0, result_out_cpu}, {56'd0, wrap_res[i]});
      check_eq("wrap_carry", {63'd0, carry_out_cpu}, {63'd0, wrap_c[i]});
      if (i == 1) begin
        prog_we = 1'b1; prog_addr = 2'd1; prog_data = ins(4'h2, 8'hFF, 8'hFF);
      end
      tick();
      prog_we = 1'b0;
      check_eq("wrap_ready_pulse", {63'd0, result_ready}, 64'd0);
    end
    next_out = 1'b0;
    wait_ready("pre_rst", n);
    rst = 1'b1;
    #1;
    check_eq("async_rst_outs", outs(), 64'd0);
    tick();
    rst = 1'b0;

    // MUL (configuration dependent), HALT at 2, restart with write+start together
    load(2'd0, ins(4'hA, 8'd16, 8'd20));
    load(2'd1, ins(4'h3, 8'hA0, 8'h05));
    load(2'd2, ins(4'hF, 8'd0, 8'd0));
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_ready("mul", n);
    check_eq("mul_res", {56'd0, result_out_cpu}, {56'd0, exp_mul});
    check_eq("mul_carry", {63'd0, carry_out_cpu}, {63'd0, exp_mulc});
    check_eq("mul_opcode", {60'd0, opcode}, 64'hA);
    accept();
    wait_ready("or", n);
    check_eq("or_res", {56'd0, result_out_cpu}, 64'hA5);
    check_eq("or_pc", {62'd0, pc_out}, 64'd1);
    accept();
    wait_halt("halt2");
    check_eq("halt2_ready", {63'd0, result_ready}, 64'd0);
    check_eq("halt2_pc", {62'd0, pc_out}, 64'd2);
    load(2'd3, ins(4'hC, 8'd5, 8'd5));
    prog_we = 1'b1; prog_addr = 2'd2; prog_data = ins(4'h5, 8'h0F, 8'h00);
    start = 1'b1;
    tick();
    prog_we = 1'b0;
    start = 1'b0;
    check_eq("restart2_halted", {63'd0, halted}, 64'd0);
    check_eq("restart2_pc", {62'd0, pc_out}, 64'd0);
    next_out = 1'b1;
    wait_ready("mul2", n);
    check_eq("mul2_res", {56'd0, result_out_cpu}, {56'd0, exp_mul});
    tick();
    wait_ready("or2", n);
    check_eq("or2_res", {56'd0, result_out_cpu}, 64'hA5);
    tick();
    wait_ready("not", n);
    check_eq("not_outs", outs(), {30'd0, 4'h5, 8'h0F, 8'h00, 8'hF0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2});
    tick();
    wait_ready("undef", n);
    check_eq("undef_outs", outs(), {30'd0, 4'hC, 8'd5, 8'd5, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd3});
    tick();
    next_out = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/param_alu_cpu.md
# param_alu_cpu

Parametrised successor to the 8-bit ALU CPU: a small programmable sequencer. It fetches instructions from an internal, loadable program memory and executes them on a WIDTH-bit ALU. Each result is presented with carry/borrow flags and held under a `result_ready`/`next_out` handshake. It sits between a program loader (bench or host) and whatever consumes the result stream.

## Interface
- `WIDTH`, default 8: operand/result width in bits (≥2).
- `DEPTH`, default 16: program memory entries, power of 2; `PC_W = $clog2(DEPTH)` (local).
- Instruction word: `{opcode[3:0], A[WIDTH-1:0], B[WIDTH-1:0]}`, `IW = 4+2*WIDTH` bits.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `prog_we` in 1: program-memory write strobe.
- `prog_addr` in PC_W: write address.
- `prog_data` in IW: write data.
- `start` in 1: begin execution at address 0.
- `next_out` in 1: consumer accepts the current result.
- `opcode` out 4: opcode of the current instruction.
- `operand_A_out` out WIDTH: operand A of the current instruction.
- `operand_B_out` out WIDTH: operand B of the current instruction.
- `result_out_cpu` out WIDTH: ALU result.
- `carry_out_cpu` out 1: carry flag.
- `borrow_out_cpu` out 1: borrow flag.
- `result_ready` out 1: result valid and held.
- `pc_out` out PC_W: address of the current instruction.
- `halted` out 1: HALT executed.

## Operation
- States: IDLE, FETCH, EXEC, HOLD, HALTED. Reset enters IDLE.
- IDLE/HALTED + `start` → FETCH, with `pc` ← 0 and `halted` ← 0.
- FETCH: instruction register ← mem[pc] → EXEC.
- EXEC: registers opcode, operands, result and flags, then → HOLD with `result_ready` ← 1. Exception: opcode 1111 (HALT) → HALTED with `halted` ← 1; `result_ready` stays 0 and `pc` is unchanged.
- HOLD: while `next_out`=0, all outputs stay frozen. When `next_out`=1: `result_ready` ← 0, `pc` ← pc+1 (wraps DEPTH-1→0), → FETCH.
- Opcodes:
  - 0000 ADD: {carry,result} = A+B.
  - 0001 SUB: result = A−B mod 2^W; borrow = (A<B).
  - 0010 AND, 0011 OR, 0100 XOR: bitwise A,B.
  - 0101 NOT: ~A.
  - 0110 SHL: A<<1; carry = A[W-1].
  - 0111 SHR: A>>1 (logical); carry = A[0].
  - 1000 INC: A+1; carry on wrap.
  - 1001 DEC: A−1; borrow = (A==0).
  - 1010 MUL: see Configuration.
  - 1111 HALT.
  - Any other opcode: result 0, flags 0; presented normally.
- Flags not listed for an opcode are 0.
- `prog_we` is honoured only in IDLE/HALTED; it is ignored in FETCH/EXEC/HOLD. Memory is not reset; write-then-read of the same address on consecutive cycles returns the new data.
- `start` is ignored outside IDLE/HALTED. If `prog_we` and `start` occur in the same cycle, both take effect.

## Timing
- Reset values: all outputs 0, state IDLE, `pc` 0.
- Asserting `rst` mid-operation immediately (asynchronously) clears `result_ready`, `halted` and all outputs.
- `start` sampled at edge k → FETCH at k; EXEC at k+1; `result_ready`=1 after edge k+2.
- `next_out` sampled high at edge m in HOLD → `result_ready`=0 after m; next `result_ready`=1 after m+2.
- Throughput with `next_out` tied high: one result per 3 cycles; `result_ready` high 1 cycle in 3.
- All outputs are registered; no combinational path from input to output.

## Configuration
- `PARAM_ALU_CPU_MUL_EN` defined: opcode 1010 produces result = low WIDTH bits of A*B and carry = 1 if the high WIDTH bits are nonzero.
- Macro undefined: no multiplier is synthesised; 1010 behaves as an undefined opcode (result 0, flags 0).

## Test plan
- WIDTH=8: mem[0]={ADD,200,100}, `start`, `next_out`=1 → 3 edges later `result_out_cpu`=44, `carry_out_cpu`=1, `result_ready`=1, `pc_out`=0.
- mem[0]={SUB,5,7}, mem[1]={DEC,0,x} → 254 with borrow 1, then 255 with borrow 1; `pc_out` 0 then 1.
- Hold `next_out`=0 for 10 cycles in HOLD → all outputs stable and `pc_out` unchanged. One-cycle `next_out` pulse → `pc_out`+1 and the next result 3 cycles later.
- DEPTH=4, no HALT, `next_out`=1 → `pc_out` sequence 0,1,2,3,0. A `prog_we` issued mid-run leaves memory unchanged.
- HALT at address 2 → after address 1 is accepted, `halted`=1, `result_ready` stays 0, `pc_out`=2. `start` restarts from `pc_out`=0 with `halted`=0.
- With the macro defined, {MUL,16,20} → result 64, carry 1; without it → result 0, carry 0. `rst` asserted in HOLD → all outputs 0 immediately.
